// File: rtl/sample_playback_engine.sv
// sample_playback_engine
// Divides clk_in by freq_count into a sample tick, fetches 32-bit words from flash over a
// waitrequest/readdatavalid read port and plays each word out as four signed 8-bit samples,
// forwards or backwards, with pause, restart and wrap-around inside the sample region.
module sample_playback_engine #(
  parameter int                N          = 32,
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [N-1:0]      freq_count,
  input  logic              play_en,
  input  logic              reverse,
  input  logic              restart,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_waitrequest,
  input  logic              mem_readdatavalid,
  input  logic [31:0]       mem_readdata,
  output logic [7:0]        audio_out,
  output logic              sample_strobe,
  output logic              underrun
);

  localparam logic [N-1:0]      CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    READY = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_read_q, mem_read_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        audio_q, audio_d;
  logic              strobe_q, strobe_d;
  logic              underrun_q, underrun_d;
  logic              restart_pend_q, restart_pend_d;
  logic [31:0]       word_q, word_d;
  logic              dir_q, dir_d;
  logic [1:0]        byte_idx_q, byte_idx_d;

  logic [N-1:0]      freq_eff;
  logic              tick;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] restart_addr;
  logic [7:0]        cur_byte;
  logic              last_byte;
  logic              apply_restart;

  // Sample-period tick: a zero period behaves like one, and >= lets a shrinking period fire at once
  always_comb begin
    freq_eff = (freq_count == '0) ? CNT_ONE : freq_count;
    tick     = play_en && (cnt_q >= (freq_eff - CNT_ONE));
  end

  // Address stepping with wrap at both ends of the region, and the restart landing point
  always_comb begin
    if (reverse) begin
      next_addr = (addr_q == START_ADDR) ? END_ADDR : (addr_q - ADDR_ONE);
    end else begin
      next_addr = (addr_q == END_ADDR) ? START_ADDR : (addr_q + ADDR_ONE);
    end
    restart_addr = reverse ? END_ADDR : START_ADDR;
  end

  // Byte currently due from the buffered word and whether it is the last one in captured order
  always_comb begin
    case (byte_idx_q)
      2'd0:    cur_byte = word_q[7:0];
      2'd1:    cur_byte = word_q[15:8];
      2'd2:    cur_byte = word_q[23:16];
      default: cur_byte = word_q[31:24];
    endcase
    last_byte = dir_q ? (byte_idx_q == 2'd0) : (byte_idx_q == 2'd3);
  end

  // Next-state logic for the fetch/playback FSM, tick counter and registered outputs
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    mem_read_d     = mem_read_q;
    mem_addr_d     = mem_addr_q;
    audio_d        = audio_q;
    strobe_d       = 1'b0;
    underrun_d     = 1'b0;
    restart_pend_d = restart_pend_q;
    word_d         = word_q;
    dir_d          = dir_q;
    byte_idx_d     = byte_idx_q;
    apply_restart  = 1'b0;

    if (play_en) begin
      cnt_d = tick ? '0 : (cnt_q + CNT_ONE);
    end

    case (state_q)
      IDLE: begin
        if (restart) begin
          apply_restart = 1'b1;
        end else begin
          underrun_d = tick;
          if (play_en) begin
            state_d    = REQ;
            mem_read_d = 1'b1;
            mem_addr_d = addr_q;
          end
        end
      end

      REQ: begin
        underrun_d = tick;
        if (restart) begin
          restart_pend_d = 1'b1;
        end
        if (!mem_waitrequest) begin
          state_d    = WAIT;
          mem_read_d = 1'b0;
        end
      end

      WAIT: begin
        underrun_d = tick;
        if (mem_readdatavalid) begin
          if (restart_pend_q || restart) begin
            apply_restart = 1'b1;
          end else begin
            word_d     = mem_readdata;
            dir_d      = reverse;
            byte_idx_d = reverse ? 2'd3 : 2'd0;
            addr_d     = next_addr;
            state_d    = READY;
          end
        end else if (restart) begin
          restart_pend_d = 1'b1;
        end
      end

      READY: begin
        if (restart) begin
          apply_restart = 1'b1;
        end else if (tick) begin
          audio_d  = cur_byte;
          strobe_d = 1'b1;
          if (last_byte) begin
            if (play_en) begin
              state_d    = REQ;
              mem_read_d = 1'b1;
              mem_addr_d = addr_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            byte_idx_d = dir_q ? (byte_idx_q - 2'd1) : (byte_idx_q + 2'd1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (apply_restart) begin
      state_d        = IDLE;
      addr_d         = restart_addr;
      cnt_d          = '0;
      mem_read_d     = 1'b0;
      restart_pend_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      addr_q         <= START_ADDR;
      mem_read_q     <= 1'b0;
      mem_addr_q     <= START_ADDR;
      audio_q        <= 8'h00;
      strobe_q       <= 1'b0;
      underrun_q     <= 1'b0;
      restart_pend_q <= 1'b0;
      word_q         <= 32'h0;
      dir_q          <= 1'b0;
      byte_idx_q     <= 2'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      mem_read_q     <= mem_read_d;
      mem_addr_q     <= mem_addr_d;
      audio_q        <= audio_d;
      strobe_q       <= strobe_d;
      underrun_q     <= underrun_d;
      restart_pend_q <= restart_pend_d;
      word_q         <= word_d;
      dir_q          <= dir_d;
      byte_idx_q     <= byte_idx_d;
    end
  end

  assign mem_read      = mem_read_q;
  assign mem_addr      = mem_addr_q;
  assign audio_out     = audio_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_sample_playback_engine.sv
// tb_sample_playback_engine
// Drives the playback engine against a small flash model and checks the played samples and
// the read addresses against expectations queued as each scenario is set up.
module tb_sample_playback_engine;

  localparam logic [22:0] START_A = 23'h0;
  localparam logic [22:0] END_A   = 23'h7FFFF;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [31:0] freq_count;
  logic        play_en;
  logic        reverse;
  logic        restart;
  logic        mem_read;
  logic [22:0] mem_addr;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;
  logic [31:0] mem_readdata;
  logic [7:0]  audio_out;
  logic        sample_strobe;
  logic        underrun;

  logic        model_valid;
  logic [31:0] model_data;
  logic        inject_valid;
  logic [31:0] inject_data;

  logic [7:0]  exp_q[$];
  logic [22:0] exp_addr_q[$];
  logic [22:0] acc_q[$];

  int checks   = 0;
  int failures = 0;
  int wait_cfg = 0;
  bit mem_hold = 1'b0;

  assign mem_readdatavalid = model_valid | inject_valid;
  assign mem_readdata      = inject_valid ? inject_data : model_data;

  sample_playback_engine dut (
    .clk_in            (clk_in),
    .reset             (reset),
    .freq_count        (freq_count),
    .play_en           (play_en),
    .reverse           (reverse),
    .restart           (restart),
    .mem_read          (mem_read),
    .mem_addr          (mem_addr),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_readdata      (mem_readdata),
    .audio_out         (audio_out),
    .sample_strobe     (sample_strobe),
    .underrun          (underrun)
  );

  always #5 clk_in = ~clk_in;

  // Flash contents: each byte of the word is a distinct pattern xor the low address byte
  function automatic logic [31:0] word_of(input logic [22:0] a);
    return {8'h44 ^ a[7:0], 8'h33 ^ a[7:0], 8'h22 ^ a[7:0], 8'h11 ^ a[7:0]};
  endfunction

  task automatic push_word(input logic [22:0] a, input bit rev);
    logic [31:0] w;
    w = word_of(a);
    if (rev) begin
      exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
    end else begin
      exp_q.push_back(w[7:0]);   exp_q.push_back(w[15:8]);
      exp_q.push_back(w[23:16]); exp_q.push_back(w[31:24]);
    end
  endtask

  // Flash model: wait_cfg cycles of waitrequest per read, data one cycle after acceptance
  initial begin : mem_model
    bit          in_req;
    bit          pend;
    int          wait_left;
    logic [22:0] pend_addr;
    in_req = 1'b0; pend = 1'b0; wait_left = 0; pend_addr = '0;
    mem_waitrequest = 1'b0; model_valid = 1'b0; model_data = 32'h0;
    forever begin
      @(negedge clk_in); #1;
      model_valid = 1'b0;
      if (reset) begin
        in_req = 1'b0; pend = 1'b0; wait_left = 0; mem_waitrequest = 1'b0;
      end else begin
        if (pend && !mem_hold) begin
          model_valid = 1'b1;
          model_data  = word_of(pend_addr);
          pend        = 1'b0;
        end
        if (mem_read) begin
          if (!in_req) begin
            in_req    = 1'b1;
            wait_left = wait_cfg;
          end
          if (wait_left > 0) begin
            mem_waitrequest = 1'b1;
            wait_left--;
          end else begin
            mem_waitrequest = 1'b0;
            in_req          = 1'b0;
            pend            = 1'b1;
            pend_addr       = mem_addr;
            acc_q.push_back(mem_addr);
          end
        end else begin
          mem_waitrequest = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    reset = 1'b1; play_en = 1'b0; restart = 1'b0; reverse = 1'b0;
    inject_valid = 1'b0; mem_hold = 1'b0; wait_cfg = 0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    exp_q.delete(); exp_addr_q.delete(); acc_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_read !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_addr !== START_A) begin failures++; $display("[TB] FAIL reset_mem_addr: got %h want %h", mem_addr, START_A); end
    checks++; if (audio_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_audio: got %h want 00", audio_out); end
    checks++; if (sample_strobe !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobe: got %b want 0", sample_strobe); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_forward();
    int last_c, ur;
    logic [7:0]  e;
    logic [22:0] ea, a;
    do_reset();
    freq_count = 4;
    push_word(START_A, 1'b0);
    exp_addr_q.push_back(START_A);
    exp_addr_q.push_back(START_A + 23'd1);
    play_en = 1'b1;
    last_c = -1; ur = 0;
    for (int c = 0; c < 60 && (exp_q.size() > 0 || acc_q.size() < 2); c++) begin
      @(negedge clk_in);
      if (underrun) ur++;
      if (sample_strobe) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("[TB] FAIL fwd_extra_strobe: got %h want no strobe", audio_out);
        end else begin
          e = exp_q.pop_front();
          if (audio_out !== e) begin failures++; $display("[TB] FAIL fwd_sample: got %h want %h", audio_out, e); end
        end
        if (last_c >= 0) begin
          checks++;
          if ((c - last_c) !== 4) begin failures++; $display("[TB] FAIL fwd_period: got %0d want 4", c - last_c); end
        end
        last_c = c;
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL fwd_timeout: got %0d samples left want 0", exp_q.size()); end
    checks++; if (ur !== 0) begin failures++; $display("[TB] FAIL fwd_underrun: got %0d want 0", ur); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      checks++;
      if (acc_q.size() == 0) begin
        failures++; $display("[TB] FAIL fwd_read_addr: got no read want %h", ea);
      end else begin
        a = acc_q.pop_front();
        if (a !== ea) begin failures++; $display("[TB] FAIL fwd_read_addr: got %h want %h", a, ea); end
      end
    end
    play_en = 1'b0;
  endtask

  task automatic test_waitrequest();
    int hi, bad;
    do_reset();
    freq_count = 1000;
    wait_cfg = 3;
    play_en = 1'b1;
    hi = 0; bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      if (mem_read === 1'b1) begin
        hi++;
        if (mem_addr !== START_A) bad++;
      end
    end
    checks++; if (hi !== 4) begin failures++; $display("[TB] FAIL wait_read_cycles: got %0d want 4", hi); end
    checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL wait_addr_stable: got %0d changes want 0", bad); end
    checks++; if (acc_q.size() !== 1) begin failures++; $display("[TB] FAIL wait_read_count: got %0d want 1", acc_q.size()); end
    if (acc_q.size() > 0) begin
      checks++; if (acc_q[0] !== START_A) begin failures++; $display("[TB] FAIL wait_read_addr: got %h want %h", acc_q[0], START_A); end
    end
    play_en = 1'b0;
  endtask

  task automatic test_reverse_wrap();
    int strobes;
    logic [7:0]  e;
    logic [22:0] ea, a;
    // Restart in reverse lands on the last word and plays it high byte first
    do_reset();
    freq_count = 4;
    reverse = 1'b1;
    restart = 1'b1;
    @(negedge clk_in);
    restart = 1'b0;
    push_word(END_A, 1'b1);
    exp_addr_q.push_back(END_A);
    exp_addr_q.push_back(END_A - 23'd1);
    play_en = 1'b1;
    for (int c = 0; c < 60 && (exp_q.size() > 0 || acc_q.size() < 2); c++) begin
      @(negedge clk_in);
      if (sample_strobe) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("[TB] FAIL rev_extra_strobe: got %h want no strobe", audio_out);
        end else begin
          e = exp_q.pop_front();
          if (audio_out !== e) begin failures++; $display("[TB] FAIL rev_sample: got %h want %h", audio_out, e); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL rev_timeout: got %0d samples left want 0", exp_q.size()); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      checks++;
      if (acc_q.size() == 0) begin
        failures++; $display("[TB] FAIL rev_read_addr: got no read want %h", ea);
      end else begin
        a = acc_q.pop_front();
        if (a !== ea) begin failures++; $display("[TB] FAIL rev_read_addr: got %h want %h", a, ea); end
      end
    end
    // Reverse from the first word wraps to the last; direction flips mid-word, forward wraps back
    do_reset();
    freq_count = 4;
    reverse = 1'b1;
    push_word(START_A, 1'b1);
    push_word(END_A, 1'b0);
    exp_addr_q.push_back(START_A);
    exp_addr_q.push_back(END_A);
    exp_addr_q.push_back(START_A);
    play_en = 1'b1;
    strobes = 0;
    for (int c = 0; c < 100 && (exp_q.size() > 0 || acc_q.size() < 3); c++) begin
      @(negedge clk_in);
      if (sample_strobe) begin
        strobes++;
        if (strobes == 1) reverse = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("[TB] FAIL wrap_extra_strobe: got %h want no strobe", audio_out);
        end else begin
          e = exp_q.pop_front();
          if (audio_out !== e) begin failures++; $display("[TB] FAIL wrap_sample: got %h want %h", audio_out, e); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL wrap_timeout: got %0d samples left want 0", exp_q.size()); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      checks++;
      if (acc_q.size() == 0) begin
        failures++; $display("[TB] FAIL wrap_read_addr: got no read want %h", ea);
      end else begin
        a = acc_q.pop_front();
        if (a !== ea) begin failures++; $display("[TB] FAIL wrap_read_addr: got %h want %h", a, ea); end
      end
    end
    play_en = 1'b0;
  endtask

  task automatic test_fast_tick();
    int ur, idle;
    logic [7:0] e;
    do_reset();
    freq_count = 614;
    play_en = 1'b1;
    repeat (100) @(negedge clk_in);
    push_word(START_A, 1'b0);
    push_word(START_A + 23'd1, 1'b0);
    push_word(START_A + 23'd2, 1'b0);
    freq_count = 1;
    ur = 0; idle = 0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk_in);
      if (c == 0) begin
        checks++;
        if (sample_strobe !== 1'b1) begin failures++; $display("[TB] FAIL fast_first_tick: got %b want 1", sample_strobe); end
      end
      if (underrun) ur++;
      if (!sample_strobe && !underrun) idle++;
      if (sample_strobe) begin
        checks++;
        e = exp_q.pop_front();
        if (audio_out !== e) begin failures++; $display("[TB] FAIL fast_sample: got %h want %h", audio_out, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL fast_timeout: got %0d samples left want 0", exp_q.size()); end
    checks++; if (ur !== 4) begin failures++; $display("[TB] FAIL fast_underruns: got %0d want 4", ur); end
    checks++; if (idle !== 0) begin failures++; $display("[TB] FAIL fast_every_cycle: got %0d quiet cycles want 0", idle); end
    freq_count = 0;
    idle = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (!sample_strobe && !underrun) idle++;
    end
    checks++; if (idle !== 0) begin failures++; $display("[TB] FAIL zero_period: got %0d quiet cycles want 0", idle); end
    play_en = 1'b0;
  endtask

  task automatic test_restart();
    int strobes;
    logic [7:0]  e;
    logic [22:0] a;
    // Restart while the read is outstanding: its data is dropped and the fetch restarts
    do_reset();
    freq_count = 4;
    mem_hold = 1'b1;
    play_en = 1'b1;
    for (int c = 0; c < 10 && acc_q.size() < 1; c++) @(negedge clk_in);
    @(negedge clk_in);
    restart = 1'b1;
    @(negedge clk_in);
    restart = 1'b0;
    repeat (2) @(negedge clk_in);
    mem_hold = 1'b0;
    strobes = 0;
    for (int c = 0; c < 30 && acc_q.size() < 2; c++) begin
      @(negedge clk_in);
      if (sample_strobe) strobes++;
    end
    checks++; if (strobes !== 0) begin failures++; $display("[TB] FAIL restart_wait_strobe: got %0d want 0", strobes); end
    checks++;
    if (acc_q.size() < 2) begin
      failures++; $display("[TB] FAIL restart_wait_refetch: got %0d reads want 2", acc_q.size());
    end else begin
      a = acc_q[1];
      if (a !== START_A) begin failures++; $display("[TB] FAIL restart_wait_refetch: got %h want %h", a, START_A); end
    end
    // Restart on the same cycle as a tick suppresses that strobe
    do_reset();
    freq_count = 4;
    exp_q.push_back(word_of(START_A) & 32'hFF);
    play_en = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk_in);
      if (sample_strobe) begin
        checks++;
        e = exp_q.pop_front();
        if (audio_out !== e) begin failures++; $display("[TB] FAIL restart_first_sample: got %h want %h", audio_out, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL restart_first_timeout: got %0d left want 0", exp_q.size()); end
    repeat (3) @(negedge clk_in);
    restart = 1'b1;
    @(negedge clk_in);
    restart = 1'b0;
    checks++; if (sample_strobe !== 1'b0) begin failures++; $display("[TB] FAIL restart_tick_strobe: got %b want 0", sample_strobe); end
    exp_q.push_back(word_of(START_A) & 32'hFF);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk_in);
      if (sample_strobe) begin
        checks++;
        e = exp_q.pop_front();
        if (audio_out !== e) begin failures++; $display("[TB] FAIL restart_replay_sample: got %h want %h", audio_out, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL restart_replay_timeout: got %0d left want 0", exp_q.size()); end
    play_en = 1'b0;
  endtask

  task automatic test_pause_and_reset();
    int strobes, ur, lat;
    logic [7:0]  e;
    logic [22:0] a;
    do_reset();
    freq_count = 4;
    push_word(START_A, 1'b0);
    play_en = 1'b1;
    strobes = 0;
    for (int c = 0; c < 40 && strobes < 2; c++) begin
      @(negedge clk_in);
      if (sample_strobe) begin
        strobes++;
        checks++;
        e = exp_q.pop_front();
        if (audio_out !== e) begin failures++; $display("[TB] FAIL pause_pre_sample: got %h want %h", audio_out, e); end
      end
    end
    play_en = 1'b0;
    strobes = 0; ur = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (sample_strobe) strobes++;
      if (underrun) ur++;
    end
    checks++; if (strobes !== 0) begin failures++; $display("[TB] FAIL pause_strobes: got %0d want 0", strobes); end
    checks++; if (ur !== 0) begin failures++; $display("[TB] FAIL pause_underruns: got %0d want 0", ur); end
    checks++; if (acc_q.size() !== 1) begin failures++; $display("[TB] FAIL pause_reads: got %0d want 1", acc_q.size()); end
    play_en = 1'b1;
    wait_cfg = 50;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk_in);
      if (sample_strobe) lat = c;
    end
    checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL resume_latency: got %0d want 4", lat); end
    if (lat != 0) begin
      checks++;
      e = exp_q.pop_front();
      if (audio_out !== e) begin failures++; $display("[TB] FAIL resume_sample: got %h want %h", audio_out, e); end
    end
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk_in);
      if (sample_strobe) begin
        checks++;
        e = exp_q.pop_front();
        if (audio_out !== e) begin failures++; $display("[TB] FAIL resume_last_sample: got %h want %h", audio_out, e); end
      end
    end
    checks++; if (mem_read !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_read: got %b want 1", mem_read); end
    reset = 1'b1;
    play_en = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
    wait_cfg = 0;
    acc_q.delete();
    checks++; if (mem_read !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_read: got %b want 0", mem_read); end
    checks++; if (audio_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_mid_audio: got %h want 00", audio_out); end
    inject_data = 32'hA5A5A5A5;
    inject_valid = 1'b1;
    @(negedge clk_in);
    inject_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(word_of(START_A) & 32'hFF);
    play_en = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk_in);
      if (sample_strobe) begin
        checks++;
        e = exp_q.pop_front();
        if (audio_out !== e) begin failures++; $display("[TB] FAIL late_valid_sample: got %h want %h", audio_out, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL late_valid_timeout: got %0d left want 0", exp_q.size()); end
    checks++;
    if (acc_q.size() == 0) begin
      failures++; $display("[TB] FAIL late_valid_read: got no read want %h", START_A);
    end else begin
      a = acc_q.pop_front();
      if (a !== START_A) begin failures++; $display("[TB] FAIL late_valid_read: got %h want %h", a, START_A); end
    end
    play_en = 1'b0;
  endtask

  initial begin : main
    reset = 1'b1; freq_count = 4; play_en = 1'b0; reverse = 1'b0; restart = 1'b0;
    inject_valid = 1'b0; inject_data = 32'h0;
    test_reset();
    test_forward();
    test_waitrequest();
    test_reverse_wrap();
    test_fast_tick();
    test_restart();
    test_pause_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
